// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the clocked daisy-chain arbiter.
package arbiter_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index width for N requesters; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/arbiter_pick.sv
// Combinational masked rotating-priority picker.
// Requests are rotated down by base using a doubled copy of the vector,
// the lowest set bit of the rotated vector wins, and its index is
// rotated back by adding base modulo N.
module arbiter_pick
   import arbiter_pkg::*;
#(
   parameter int N  = 8,
   parameter int IW = idx_w(N)
)
(
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx,
   output logic          any
);

   localparam logic [IW:0] N_EXT = (IW + 1)'(N);

   logic [N-1:0]  masked;
   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW:0]   sum;

   assign masked = req & ~mask;
   assign any    = |masked;

   // Rotate, find the first requester after base, then map its offset back to an absolute index.
   always_comb begin
      rot = N'({masked, masked} >> base);
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = i[IW-1:0];
         end
      end
      sum = {1'b0, off} + {1'b0, base};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      win_idx = sum[IW-1:0];
      win     = '0;
      if (any) begin
         win[win_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/arbiter_chain_rr.sv
// Clocked daisy-chain arbiter with registered one-hot grant, hold timeout,
// fixed-priority or round-robin selection, and en_in/en_out cascading.
module arbiter_chain_rr
   import arbiter_pkg::*;
#(
   parameter int N        = 8,
   parameter int MODE     = ARB_FIXED,
   parameter int MAX_HOLD = 0
)
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en_in,
   input  logic [0:N-1]          req,
   output logic [0:N-1]          gnt,
   output logic                  gnt_valid,
   output logic [idx_w(N)-1:0]   gnt_idx,
   output logic                  any_req,
   output logic                  en_out
);

   localparam int IW = idx_w(N);
   localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [IW-1:0] LAST     = IW'(N - 1);

   if (N < 1) begin : g_bad_n
      $error("arbiter_chain_rr: N must be at least 1");
   end

   state_t        state_reg;
   logic [N-1:0]  gnt_reg;
   logic [IW-1:0] idx_reg;
   logic [IW-1:0] ptr_reg;
   logic [HW-1:0] hold_cnt_reg;

   logic [N-1:0]  req_v;
   logic [N-1:0]  mask;
   logic [IW-1:0] base;
   logic [N-1:0]  pick_win;
   logic [IW-1:0] pick_idx;
   logic          pick_any;
   logic          held;
   logic          timeout;
   logic [N-1:0]  grant_vec;
   logic [IW-1:0] grant_idx;

   // Ports are [0:N-1]; internal vectors are [N-1:0] with the same bit numbering.
   for (genvar gi = 0; gi < N; gi++) begin : g_bits
      assign req_v[gi] = req[gi];
      assign gnt[gi]   = gnt_reg[gi];
   end

   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] k);
      return (k == LAST) ? '0 : k + IW'(1);
   endfunction

   arbiter_pick #(.N(N), .IW(IW)) u_pick (
      .req     (req_v),
      .mask    (mask),
      .base    (base),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   // Hold/timeout decode and picker controls; a timed-out winner is masked for one arbitration.
   always_comb begin
      held    = req_v[idx_reg];
      timeout = (MAX_HOLD != 0) && (hold_cnt_reg >= HOLD_MAX);
      mask    = '0;
      if ((state_reg == GRANT) && held && timeout) begin
         mask[idx_reg] = 1'b1;
      end
      base = (MODE == ARB_RR) ? ptr_reg : '0;
      // With the current winner masked and nobody else asking, it simply wins again.
      grant_vec = pick_any ? pick_win : gnt_reg;
      grant_idx = pick_any ? pick_idx : idx_reg;
   end

   // Grant FSM with registered outputs, round-robin pointer and hold counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         gnt_reg      <= '0;
         idx_reg      <= '0;
         ptr_reg      <= '0;
         hold_cnt_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (en_in && any_req) begin
                  state_reg    <= GRANT;
                  gnt_reg      <= grant_vec;
                  idx_reg      <= grant_idx;
                  hold_cnt_reg <= HW'(1);
                  if (MODE == ARB_RR) ptr_reg <= next_ptr(grant_idx);
               end
            end
            GRANT: begin
               if (!en_in) begin
                  state_reg    <= IDLE;
                  gnt_reg      <= '0;
                  idx_reg      <= '0;
                  hold_cnt_reg <= '0;
               end else if (held && !timeout) begin
                  if (MAX_HOLD != 0) hold_cnt_reg <= hold_cnt_reg + HW'(1);
               end else if (held || any_req) begin
                  gnt_reg      <= grant_vec;
                  idx_reg      <= grant_idx;
                  hold_cnt_reg <= HW'(1);
                  if (MODE == ARB_RR) ptr_reg <= next_ptr(grant_idx);
               end else begin
                  state_reg    <= IDLE;
                  gnt_reg      <= '0;
                  idx_reg      <= '0;
                  hold_cnt_reg <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gnt_valid = |gnt_reg;
   assign gnt_idx   = idx_reg;
   assign any_req   = |req_v;
   assign en_out    = en_in & ~any_req & (state_reg == IDLE);

endmodule

// File: tb/tb_arbiter_chain_rr.sv
// Self-checking bench: directed corner cases, a vector table and a
// randomized two-stage chain compared against a behavioural model.
module tb_arbiter_chain_rr;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Fixed priority, unlimited hold
   logic [0:7] req_f, gnt_f;
   logic en_f, gv_f, ar_f, eo_f;
   logic [2:0] gi_f;
   // Round robin, MAX_HOLD=1
   logic [0:7] req_r, gnt_r;
   logic en_r, gv_r, ar_r, eo_r;
   logic [2:0] gi_r;
   // Fixed priority, MAX_HOLD=4
   logic [0:7] req_h, gnt_h;
   logic en_h, gv_h, ar_h, eo_h;
   logic [2:0] gi_h;
   // Chain A -> B, round robin, MAX_HOLD=3
   logic [0:7] req_a, gnt_a, req_b, gnt_b;
   logic en_a, gv_a, ar_a, eo_a, gv_b, ar_b, eo_b;
   logic [2:0] gi_a, gi_b;

   arbiter_chain_rr #(.N(8), .MODE(0), .MAX_HOLD(0)) u_fix (
      .clk(clk), .reset_n(reset_n), .en_in(en_f), .req(req_f), .gnt(gnt_f),
      .gnt_valid(gv_f), .gnt_idx(gi_f), .any_req(ar_f), .en_out(eo_f));
   arbiter_chain_rr #(.N(8), .MODE(1), .MAX_HOLD(1)) u_rr1 (
      .clk(clk), .reset_n(reset_n), .en_in(en_r), .req(req_r), .gnt(gnt_r),
      .gnt_valid(gv_r), .gnt_idx(gi_r), .any_req(ar_r), .en_out(eo_r));
   arbiter_chain_rr #(.N(8), .MODE(0), .MAX_HOLD(4)) u_fx4 (
      .clk(clk), .reset_n(reset_n), .en_in(en_h), .req(req_h), .gnt(gnt_h),
      .gnt_valid(gv_h), .gnt_idx(gi_h), .any_req(ar_h), .en_out(eo_h));
   arbiter_chain_rr #(.N(8), .MODE(1), .MAX_HOLD(3)) u_a (
      .clk(clk), .reset_n(reset_n), .en_in(en_a), .req(req_a), .gnt(gnt_a),
      .gnt_valid(gv_a), .gnt_idx(gi_a), .any_req(ar_a), .en_out(eo_a));
   arbiter_chain_rr #(.N(8), .MODE(1), .MAX_HOLD(3)) u_b (
      .clk(clk), .reset_n(reset_n), .en_in(eo_a), .req(req_b), .gnt(gnt_b),
      .gnt_valid(gv_b), .gnt_idx(gi_b), .any_req(ar_b), .en_out(eo_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model of one chain stage (RR, MAX_HOLD=3) ----------------
   int mk[2];   // granted index, -1 when idle
   int mc[2];   // consecutive grant cycles of the current winner
   int mp[2];   // round-robin start position

   function automatic int pick(input logic [0:7] r, input int excl, input int start);
      for (int o = 0; o < 8; o++) begin
         int i;
         i = (start + o) % 8;
         if (r[i] && i != excl) return i;
      end
      return -1;
   endfunction

   task automatic mgrant(input int s, input int w);
      mk[s] = w;
      mc[s] = 1;
      mp[s] = (w + 1) % 8;
   endtask

   task automatic mstep(input int s, input logic [0:7] r, input logic en);
      int w;
      if (mk[s] < 0) begin
         if (en && r != 8'h00) mgrant(s, pick(r, -1, mp[s]));
      end else if (!en) begin
         mk[s] = -1;
      end else if (r[mk[s]] && mc[s] < 3) begin
         mc[s]++;
      end else if (r[mk[s]]) begin
         w = pick(r, mk[s], mp[s]);
         mgrant(s, (w < 0) ? mk[s] : w);
      end else if (r != 8'h00) begin
         mgrant(s, pick(r, -1, mp[s]));
      end else begin
         mk[s] = -1;
      end
   endtask

   function automatic logic [0:7] onehot(input int k);
      logic [0:7] v;
      v = '0;
      if (k >= 0) v[k] = 1'b1;
      return v;
   endfunction

   typedef struct {
      logic [0:7] req;
      logic       en;
      int         exp_idx;
      logic       exp_valid;
   } vec_t;
   vec_t vecs[10];

   initial begin
      logic [0:7] ra, rb, ea, eb;
      logic       ena, enb_m;
      int         e;

      req_f = '0; req_r = '0; req_h = '0; req_a = '0; req_b = '0;
      en_f = 1'b1; en_r = 1'b1; en_h = 1'b1; en_a = 1'b1;
      reset_n = 1'b0;
      tick(); tick();
      reset_n = 1'b1;

      // Reset state
      chk("reset_gnt", 32'(gnt_f), 0);
      chk("reset_valid", 32'(gv_f), 0);
      chk("reset_idx", 32'(gi_f), 0);
      chk("reset_en_out", 32'(eo_f), 1);
      chk("reset_any_req", 32'(ar_f), 0);

      // Fixed priority: lowest set index wins, one edge later
      req_f = 8'b0011_0100;
      #1;
      chk("any_req_comb", 32'(ar_f), 1);
      chk("en_out_req", 32'(eo_f), 0);
      chk("no_comb_grant", 32'(gv_f), 0);
      tick();
      chk("fix_first_gnt", 32'(gnt_f), 32'(8'b0010_0000));
      chk("fix_first_idx", 32'(gi_f), 2);
      $display("fixed: req=%b gnt=%b idx=%0d", req_f, gnt_f, gi_f);

      // Hold for 10 cycles, then release hands over without a bubble
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("hold_idx", 32'(gi_f), 2);
         chk("hold_valid", 32'(gv_f), 1);
      end
      req_f = 8'b0001_0100;
      tick();
      chk("handover_idx", 32'(gi_f), 3);
      chk("handover_valid", 32'(gv_f), 1);
      $display("handover: req=%b gnt=%b idx=%0d", req_f, gnt_f, gi_f);
      req_f = '0;
      tick();
      chk("release_idle", 32'(gv_f), 0);

      // Table of single-edge vectors on the fixed instance, starting from IDLE
      vecs[0] = '{8'b0011_0100, 1'b1, 2, 1'b1};
      vecs[1] = '{8'b0011_0100, 1'b1, 2, 1'b1};
      vecs[2] = '{8'b0001_0100, 1'b1, 3, 1'b1};
      vecs[3] = '{8'b1001_0100, 1'b1, 3, 1'b1};
      vecs[4] = '{8'b1000_0100, 1'b1, 0, 1'b1};
      vecs[5] = '{8'b1000_0100, 1'b0, 0, 1'b0};
      vecs[6] = '{8'b0000_0001, 1'b1, 7, 1'b1};
      vecs[7] = '{8'b0000_0000, 1'b1, 0, 1'b0};
      vecs[8] = '{8'b0100_0000, 1'b0, 0, 1'b0};
      vecs[9] = '{8'b0100_0000, 1'b1, 1, 1'b1};
      for (int v = 0; v < 10; v++) begin
         req_f = vecs[v].req;
         en_f  = vecs[v].en;
         tick();
         chk($sformatf("vec%0d_idx", v), 32'(gi_f), 32'(vecs[v].exp_idx));
         chk($sformatf("vec%0d_valid", v), 32'(gv_f), 32'(vecs[v].exp_valid));
         chk($sformatf("vec%0d_gnt", v), 32'(gnt_f),
             32'(vecs[v].exp_valid ? onehot(vecs[v].exp_idx) : 8'h00));
         $display("vec%0d: req=%b en=%b gnt=%b idx=%0d", v, req_f, en_f, gnt_f, gi_f);
      end
      req_f = '0; en_f = 1'b1;

      // Round robin with MAX_HOLD=1 walks every index
      req_r = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_walk_idx", 32'(gi_r), 32'(i % 8));
         chk("rr_walk_gnt", 32'(gnt_r), 32'(onehot(i % 8)));
         $display("rr: edge=%0d idx=%0d", i, gi_r);
      end
      req_r = '0;

      // Fixed priority with MAX_HOLD=4 alternates on timeout
      req_h = 8'b1100_0000;
      for (e = 0; e < 9; e++) begin
         tick();
         chk("timeout_idx", 32'(gi_h), (e < 4) ? 0 : ((e < 8) ? 1 : 0));
         chk("timeout_valid", 32'(gv_h), 1);
         $display("hold4: edge=%0d idx=%0d", e, gi_h);
      end
      req_h = 8'b0100_0000;
      for (e = 0; e < 6; e++) begin
         tick();
         chk("sole_regrant_idx", 32'(gi_h), 1);
         chk("sole_regrant_valid", 32'(gv_h), 1);
      end
      req_h = '0;

      // Chain: upstream request preempts the downstream grant
      req_b = 8'h01;
      tick();
      chk("chain_b_idx", 32'(gi_b), 7);
      chk("chain_b_valid", 32'(gv_b), 1);
      chk("chain_en_out", 32'(eo_a), 1);
      req_a = 8'h80;
      #1;
      chk("chain_en_out_drop", 32'(eo_a), 0);
      tick();
      chk("chain_b_preempt", 32'(gv_b), 0);
      chk("chain_a_idx", 32'(gi_a), 0);
      chk("chain_a_valid", 32'(gv_a), 1);
      $display("chain: gnt_a=%b gnt_b=%b", gnt_a, gnt_b);

      // Reset in the middle of a grant; pointer returns to 0
      req_a = 8'b0000_0100;
      req_b = '0;
      tick();
      chk("pre_reset_idx", 32'(gi_a), 5);
      reset_n = 1'b0;
      tick();
      chk("mid_reset_gnt", 32'(gnt_a), 0);
      chk("mid_reset_idx", 32'(gi_a), 0);
      reset_n = 1'b1;
      req_a = 8'hFF;
      tick();
      chk("ptr_after_reset", 32'(gi_a), 0);

      // Randomized chain against the model
      req_a = '0; req_b = '0; en_a = 1'b1;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int s = 0; s < 2; s++) begin
         mk[s] = -1; mc[s] = 0; mp[s] = 0;
      end
      ra = '0; rb = '0; ena = 1'b1;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if ($urandom_range(0, 9) < 3) ra = 8'($urandom) & 8'($urandom) & 8'($urandom);
         if ($urandom_range(0, 9) < 3) rb = 8'($urandom) & 8'($urandom);
         ena = ($urandom_range(0, 9) != 0);
         req_a = ra; req_b = rb; en_a = ena;
         #1;
         enb_m = ena && (ra == 8'h00) && (mk[0] < 0);
         chk("rnd_en_out", 32'(eo_a), 32'(enb_m));
         chk("rnd_any_req", 32'(ar_b), 32'(rb != 8'h00));
         mstep(0, ra, ena);
         mstep(1, rb, enb_m);
         tick();
         ea = onehot(mk[0]);
         eb = onehot(mk[1]);
         chk("rnd_gnt_a", 32'(gnt_a), 32'(ea));
         chk("rnd_gnt_b", 32'(gnt_b), 32'(eb));
         chk("rnd_idx_a", 32'(gi_a), (mk[0] < 0) ? 0 : mk[0]);
         chk("rnd_idx_b", 32'(gi_b), (mk[1] < 0) ? 0 : mk[1]);
         chk("rnd_onehot_a", 32'($countones(gnt_a) <= 1), 1);
         chk("rnd_onehot_b", 32'($countones(gnt_b) <= 1), 1);
         chk("rnd_chain_excl", 32'(gv_a & gv_b), 0);
         chk("rnd_gnt_has_req_a", 32'((gnt_a & ~ra) == 8'h00), 1);
         chk("rnd_gnt_has_req_b", 32'((gnt_b & ~rb) == 8'h00), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
